// File: rtl/spectrum_pkg.sv
// Shared types and constants for the audio capture / FFT feed path.
// Holds the bank and reader state encodings and the overrun counter helper.
package spectrum_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_READING = 2'd3
    } bank_state_e;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_FETCH  = 2'd1,
        RD_STREAM = 2'd2
    } rd_state_e;

    localparam int unsigned I2S_SKIP_BITS = 1;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/i2s_rx_sync.sv
// Codec pin synchronizers, BCLK rise detection and left-channel I2S deserializer.
// Produces one sample_strobe pulse per completed left-channel word.
module i2s_rx_sync
    import spectrum_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                aud_bclk,
    input  logic                aud_adclrck,
    input  logic                aud_adcdat,
    output logic                sample_strobe,
    output logic [SAMPLE_W-1:0] sample
);

    localparam int unsigned CNT_W = $clog2(I2S_SKIP_BITS + SAMPLE_W + 1);
    localparam logic [CNT_W-1:0] SKIP_CNT = CNT_W'(I2S_SKIP_BITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(I2S_SKIP_BITS + SAMPLE_W - 1);

    // Bit order in the synchronizer vectors: {bclk, lrck, dat}
    logic [2:0]          meta_q, meta_d, sync_q, sync_d;
    logic                bclk_prev_q, bclk_prev_d;
    logic                lrck_prev_q, lrck_prev_d;
    logic                armed_q, armed_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_W-1:0] shift_q, shift_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                strobe_q, strobe_d;
    logic                bclk_rise_s;

    assign bclk_rise_s = sync_q[2] & ~bclk_prev_q;

    // Deserializer next state: arm on LRCK falling, skip one rise, shift SAMPLE_W bits
    always_comb begin
        meta_d      = {aud_bclk, aud_adclrck, aud_adcdat};
        sync_d      = meta_q;
        bclk_prev_d = sync_q[2];
        lrck_prev_d = bclk_rise_s ? sync_q[1] : lrck_prev_q;
        armed_d     = armed_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        sample_d    = sample_q;
        strobe_d    = 1'b0;
        if (!enable) begin
            armed_d   = 1'b0;
            bit_cnt_d = '0;
        end else if (bclk_rise_s && armed_q) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q >= SKIP_CNT) begin
                shift_d = {shift_q[SAMPLE_W-2:0], sync_q[0]};
            end else begin
                shift_d = shift_q;
            end
            if (bit_cnt_q == LAST_CNT) begin
                armed_d  = 1'b0;
                strobe_d = 1'b1;
                sample_d = {shift_q[SAMPLE_W-2:0], sync_q[0]};
            end else begin
                armed_d  = 1'b1;
            end
        end else if (bclk_rise_s && lrck_prev_q && !sync_q[1]) begin
            armed_d   = 1'b1;
            bit_cnt_d = '0;
        end else begin
            armed_d   = armed_q;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q      <= 3'b000;
            sync_q      <= 3'b000;
            bclk_prev_q <= 1'b0;
            lrck_prev_q <= 1'b0;
            armed_q     <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            sample_q    <= '0;
            strobe_q    <= 1'b0;
        end else begin
            meta_q      <= meta_d;
            sync_q      <= sync_d;
            bclk_prev_q <= bclk_prev_d;
            lrck_prev_q <= lrck_prev_d;
            armed_q     <= armed_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            sample_q    <= sample_d;
            strobe_q    <= strobe_d;
        end
    end

    assign sample_strobe = strobe_q;
    assign sample        = sample_q;

endmodule

// File: rtl/audio_frame_scheduler.sv
// Ping-pong frame buffer between the I2S capture path and the FFT input stream.
// Capture fills one bank while the reader streams the other; samples drop when both are busy.
module audio_frame_scheduler
    import spectrum_pkg::*;
#(
    parameter int unsigned SAMPLE_W  = 16,
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned ADDR_W    = $clog2(FRAME_LEN)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                aud_bclk,
    input  logic                aud_adclrck,
    input  logic                aud_adcdat,
    input  logic                fft_ready,
    output logic                fft_valid,
    output logic [SAMPLE_W-1:0] fft_data,
    output logic                fft_sop,
    output logic                fft_eop,
    output logic                overrun,
    output logic [7:0]          overrun_count,
    output logic [15:0]         frame_count
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

    logic                sample_strobe_s;
    logic [SAMPLE_W-1:0] sample_s;

    bank_state_e         bank_q [2];
    bank_state_e         bank_d [2];
    logic                fill_q, fill_d;
    logic [ADDR_W-1:0]   wr_idx_q, wr_idx_d;
    rd_state_e           rd_state_q, rd_state_d;
    logic                rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0]   rd_idx_q, rd_idx_d;
    logic                valid_q, valid_d;
    logic                sop_q, sop_d;
    logic                eop_q, eop_d;
    logic                overrun_q, overrun_d;
    logic [7:0]          ovr_cnt_q, ovr_cnt_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;

    logic [SAMPLE_W-1:0] mem [2*FRAME_LEN];
    logic [SAMPLE_W-1:0] rd_data_q;
    logic                we_s, re_s, drop_s, accept_s;
    logic [ADDR_W:0]     waddr_s, raddr_s;
    logic [ADDR_W-1:0]   rd_idx_nxt_s;

    i2s_rx_sync #(.SAMPLE_W(SAMPLE_W)) u_rx (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .aud_bclk      (aud_bclk),
        .aud_adclrck   (aud_adclrck),
        .aud_adcdat    (aud_adcdat),
        .sample_strobe (sample_strobe_s),
        .sample        (sample_s)
    );

    assign accept_s     = valid_q & fft_ready;
    assign rd_idx_nxt_s = rd_idx_q + ADDR_W'(1);

    // Reader FSM first, then capture; capture sees a bank the reader frees this cycle
    always_comb begin
        bank_d      = bank_q;
        fill_d      = fill_q;
        wr_idx_d    = wr_idx_q;
        rd_state_d  = rd_state_q;
        rd_bank_d   = rd_bank_q;
        rd_idx_d    = rd_idx_q;
        valid_d     = valid_q;
        sop_d       = sop_q;
        eop_d       = eop_q;
        frame_cnt_d = frame_cnt_q;
        re_s        = 1'b0;
        raddr_s     = {rd_bank_q, rd_idx_q};
        we_s        = 1'b0;
        waddr_s     = {fill_q, wr_idx_q};
        drop_s      = 1'b0;

        case (rd_state_q)
            RD_IDLE: begin
                if (bank_q[rd_bank_q] == BANK_FULL) begin
                    rd_state_d = RD_FETCH;
                end else begin
                    rd_state_d = RD_IDLE;
                end
            end
            RD_FETCH: begin
                bank_d[rd_bank_q] = BANK_READING;
                re_s       = 1'b1;
                raddr_s    = {rd_bank_q, {ADDR_W{1'b0}}};
                rd_idx_d   = '0;
                valid_d    = 1'b1;
                sop_d      = 1'b1;
                eop_d      = 1'b0;
                rd_state_d = RD_STREAM;
            end
            RD_STREAM: begin
                if (accept_s && (rd_idx_q == LAST_IDX)) begin
                    bank_d[rd_bank_q] = BANK_EMPTY;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    rd_bank_d   = ~rd_bank_q;
                    valid_d     = 1'b0;
                    sop_d       = 1'b0;
                    eop_d       = 1'b0;
                    rd_state_d  = (bank_q[~rd_bank_q] == BANK_FULL) ? RD_FETCH : RD_IDLE;
                end else if (accept_s) begin
                    re_s     = 1'b1;
                    raddr_s  = {rd_bank_q, rd_idx_nxt_s};
                    rd_idx_d = rd_idx_nxt_s;
                    sop_d    = 1'b0;
                    eop_d    = (rd_idx_nxt_s == LAST_IDX);
                end else begin
                    rd_state_d = RD_STREAM;
                end
            end
            default: begin
                rd_state_d = RD_IDLE;
            end
        endcase

        // Claim the target bank as soon as it is free; until then strobes are drops
        if (bank_d[fill_q] == BANK_EMPTY) begin
            bank_d[fill_q] = BANK_FILLING;
        end else begin
            bank_d[fill_q] = bank_d[fill_q];
        end

        if (!enable) begin
            wr_idx_d = '0;
        end else if (sample_strobe_s && (bank_d[fill_q] == BANK_FILLING)) begin
            we_s = 1'b1;
            if (wr_idx_q == LAST_IDX) begin
                bank_d[fill_q] = BANK_FULL;
                wr_idx_d       = '0;
                fill_d         = ~fill_q;
                if (bank_d[~fill_q] == BANK_EMPTY) begin
                    bank_d[~fill_q] = BANK_FILLING;
                end else begin
                    bank_d[~fill_q] = bank_d[~fill_q];
                end
            end else begin
                wr_idx_d = wr_idx_q + ADDR_W'(1);
            end
        end else if (sample_strobe_s) begin
            drop_s = 1'b1;
        end else begin
            wr_idx_d = wr_idx_q;
        end

        overrun_d = drop_s;
        ovr_cnt_d = drop_s ? sat_inc8(ovr_cnt_q) : ovr_cnt_q;
    end

    // Sample buffer write port
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem[waddr_s] <= sample_s;
        end
    end

    // Synchronous read; this register also drives fft_data directly
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else if (re_s) begin
            rd_data_q <= mem[raddr_s];
        end
    end

    // Control and status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bank_q[0]   <= BANK_EMPTY;
            bank_q[1]   <= BANK_EMPTY;
            fill_q      <= 1'b0;
            wr_idx_q    <= '0;
            rd_state_q  <= RD_IDLE;
            rd_bank_q   <= 1'b0;
            rd_idx_q    <= '0;
            valid_q     <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            overrun_q   <= 1'b0;
            ovr_cnt_q   <= 8'd0;
            frame_cnt_q <= 16'd0;
        end else begin
            bank_q      <= bank_d;
            fill_q      <= fill_d;
            wr_idx_q    <= wr_idx_d;
            rd_state_q  <= rd_state_d;
            rd_bank_q   <= rd_bank_d;
            rd_idx_q    <= rd_idx_d;
            valid_q     <= valid_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            overrun_q   <= overrun_d;
            ovr_cnt_q   <= ovr_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign fft_valid     = valid_q;
    assign fft_data      = rd_data_q;
    assign fft_sop       = sop_q;
    assign fft_eop       = eop_q;
    assign overrun       = overrun_q;
    assign overrun_count = ovr_cnt_q;
    assign frame_count   = frame_cnt_q;

endmodule

// File: tb/tb_audio_frame_scheduler.sv
// Scoreboard bench for audio_frame_scheduler with a behavioural I2S codec driver.
// Uses a 16-sample frame so that saturation and multi-frame scenarios stay short.
`timescale 1ns/1ps
module tb_audio_frame_scheduler;

    localparam int FL = 16;

    typedef struct packed {
        logic [15:0] data;
        logic        sop;
        logic        eop;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        aud_bclk;
    logic        aud_adclrck;
    logic        aud_adcdat;
    logic        fft_ready;
    logic        fft_valid;
    logic [15:0] fft_data;
    logic        fft_sop;
    logic        fft_eop;
    logic        overrun;
    logic [7:0]  overrun_count;
    logic [15:0] frame_count;

    exp_t        exp_q[$];
    int          n_vec;
    int          n_err;
    int          ready_mode;
    int          ovr_pulses;
    int          snap;
    bit          found;

    audio_frame_scheduler #(.SAMPLE_W(16), .FRAME_LEN(FL)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .aud_bclk      (aud_bclk),
        .aud_adclrck   (aud_adclrck),
        .aud_adcdat    (aud_adcdat),
        .fft_ready     (fft_ready),
        .fft_valid     (fft_valid),
        .fft_data      (fft_data),
        .fft_sop       (fft_sop),
        .fft_eop       (fft_eop),
        .overrun       (overrun),
        .overrun_count (overrun_count),
        .frame_count   (frame_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] data, input int idx);
        exp_t e;
        e.data = data;
        e.sop  = (idx == 0);
        e.eop  = (idx == FL - 1);
        exp_q.push_back(e);
    endtask

    task automatic slot();
        #40 aud_bclk = 1'b1;
        #40 aud_bclk = 1'b0;
    endtask

    // One stereo word: right half first, then left half (arm rise, skip rise, 16 data rises)
    task automatic send(input logic [15:0] left, input logic [15:0] right, input bit long_right);
        int nr;
        nr = long_right ? 18 : 2;
        for (int s = 0; s < nr; s++) begin
            aud_adclrck = 1'b1;
            aud_adcdat  = (long_right && s >= 2) ? right[17-s] : 1'b0;
            slot();
        end
        for (int s = 0; s < 18; s++) begin
            aud_adclrck = 1'b0;
            aud_adcdat  = (s >= 2) ? left[17-s] : 1'b1;
            slot();
        end
    endtask

    task automatic wait_drain(input int max_cyc);
        for (int c = 0; c < max_cyc && exp_q.size() != 0; c++) @(negedge clk);
        repeat (4) @(negedge clk);
        check_eq("drain", exp_q.size(), 0);
    endtask

    initial begin
        int cyc3;
        cyc3 = 0;
        fft_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc3 = (cyc3 == 2) ? 0 : cyc3 + 1;
            case (ready_mode)
                0:       fft_ready = 1'b1;
                1:       fft_ready = (cyc3 == 0);
                default: fft_ready = 1'b0;
            endcase
        end
    end

    // Output monitor: scoreboard pops, stall stability, no gaps inside a frame
    initial begin
        bit          in_frame;
        bit          prev_stall;
        logic [15:0] prev_data;
        logic        prev_sop, prev_eop;
        exp_t        e;
        in_frame   = 1'b0;
        prev_stall = 1'b0;
        ovr_pulses = 0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (prev_stall) begin
                    check_eq("hold_valid", fft_valid, 1);
                    check_eq("hold_data", fft_data, prev_data);
                    check_eq("hold_sop", fft_sop, prev_sop);
                    check_eq("hold_eop", fft_eop, prev_eop);
                end
                if (in_frame) check_eq("no_gap", fft_valid, 1);
                if (fft_valid && fft_ready) begin
                    check_eq("sb_nonempty", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check_eq("data", fft_data, e.data);
                        check_eq("sop", fft_sop, e.sop);
                        check_eq("eop", fft_eop, e.eop);
                    end
                    in_frame = !fft_eop;
                end
                prev_stall = fft_valid && !fft_ready;
                prev_data  = fft_data;
                prev_sop   = fft_sop;
                prev_eop   = fft_eop;
                if (overrun) ovr_pulses++;
            end else begin
                in_frame   = 1'b0;
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        ready_mode  = 0;
        reset_n     = 1'b0;
        enable      = 1'b1;
        aud_bclk    = 1'b0;
        aud_adclrck = 1'b1;
        aud_adcdat  = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("rst_valid", fft_valid, 0);
        check_eq("rst_data", fft_data, 0);
        check_eq("rst_sop", fft_sop, 0);
        check_eq("rst_eop", fft_eop, 0);
        check_eq("rst_overrun", overrun, 0);
        check_eq("rst_ovr_cnt", overrun_count, 0);
        check_eq("rst_frames", frame_count, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Ramp frame, continuous ready
        for (int i = 0; i < FL; i++) begin
            push_exp(16'(i), i);
            send(16'(i), 16'hAAAA, 1'b0);
        end
        wait_drain(100);
        check_eq("t1_frames", frame_count, 1);
        check_eq("t1_ovr_cnt", overrun_count, 0);

        // Ready high one cycle in three
        ready_mode = 1;
        for (int i = 0; i < FL; i++) begin
            push_exp(16'h0100 + 16'(i), i);
            send(16'h0100 + 16'(i), 16'h0000, 1'b0);
        end
        wait_drain(200);
        ready_mode = 0;
        check_eq("t2_frames", frame_count, 2);
        check_eq("t2_ovr_cnt", overrun_count, 0);

        // Sink blocked: two frames buffered, the third drops and the counter saturates
        ready_mode = 2;
        snap = ovr_pulses;
        for (int i = 0; i < 2 * FL; i++) begin
            push_exp(16'h0200 + 16'(i), i % FL);
            send(16'h0200 + 16'(i), 16'h0000, 1'b0);
        end
        for (int i = 0; i < 256; i++) send(16'h0300 + 16'(i), 16'h0000, 1'b0);
        repeat (5) @(negedge clk);
        check_eq("t3_ovr_sat", overrun_count, 255);
        check_eq("t3_ovr_pulses", ovr_pulses - snap, 256);
        check_eq("t3_frames_stalled", frame_count, 2);
        ready_mode = 0;
        for (int i = 0; i < FL; i++) begin
            push_exp(16'h0400 + 16'(i), i);
            send(16'h0400 + 16'(i), 16'h0000, 1'b0);
        end
        wait_drain(300);
        check_eq("t3_frames", frame_count, 5);
        check_eq("t3_ovr_hold", overrun_count, 255);

        // Partial frame discarded by enable low
        for (int i = 0; i < 6; i++) send(16'h0500 + 16'(i), 16'h0000, 1'b0);
        repeat (10) @(negedge clk);
        enable = 1'b0;
        repeat (20) @(negedge clk);
        enable = 1'b1;
        repeat (5) @(negedge clk);
        for (int i = 0; i < FL; i++) begin
            push_exp(16'h0600 + 16'(i), i);
            send(16'h0600 + 16'(i), 16'h0000, 1'b0);
        end
        wait_drain(100);
        check_eq("t4_frames", frame_count, 6);

        // Reset while streaming index 5
        for (int i = 0; i < FL; i++) begin
            push_exp(16'h0700 + 16'(i), i);
            send(16'h0700 + 16'(i), 16'h0000, 1'b0);
        end
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            @(negedge clk);
            if (fft_valid && fft_data == 16'h0705) found = 1'b1;
        end
        check_eq("t5_reach_idx5", found, 1);
        reset_n = 1'b0;
        #1;
        check_eq("t5_valid", fft_valid, 0);
        check_eq("t5_sop", fft_sop, 0);
        check_eq("t5_eop", fft_eop, 0);
        check_eq("t5_frames", frame_count, 0);
        check_eq("t5_ovr_cnt", overrun_count, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < FL; i++) begin
            push_exp(16'h0800 + 16'(i), i);
            send(16'h0800 + 16'(i), 16'h0000, 1'b0);
        end
        wait_drain(100);
        check_eq("t5_frames_after", frame_count, 1);

        // Right channel carries 0xAAAA; only the left word may reach the FFT
        for (int i = 0; i < FL; i++) begin
            push_exp(16'h1234, i);
            send(16'h1234, 16'hAAAA, 1'b1);
        end
        wait_drain(100);
        check_eq("t6_frames", frame_count, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/audio_frame_scheduler.md
# audio_frame_scheduler

Captures left-channel I2S samples from the audio codec ADC and assembles them into fixed-length frames in a ping-pong buffer. Schedules each complete frame onto the FFT input stream with valid/ready, start-of-packet and end-of-packet framing. Sits between the codec pins (BCLK/ADCLRCK/ADCDAT) and the FFT core inside the audio subsystem. Reports dropped samples when the FFT cannot keep pace.

## Interface
- SAMPLE_W, 16, bits per captured sample (two's complement, MSB first on the wire)
- FRAME_LEN, 256, samples per frame; power of two, 16..1024
- ADDR_W, $clog2(FRAME_LEN), buffer index width
- clk  in  1  system clock; one clock domain; ≥ 8× BCLK frequency
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  capture enable; level
- aud_bclk  in  1  codec bit clock, asynchronous to clk
- aud_adclrck  in  1  codec ADC LR clock, asynchronous; low = left
- aud_adcdat  in  1  codec ADC serial data, asynchronous
- fft_ready  in  1  FFT sink ready
- fft_valid  out  1  sample valid toward FFT
- fft_data  out  SAMPLE_W  sample toward FFT
- fft_sop  out  1  high with the frame's first sample
- fft_eop  out  1  high with the frame's last sample
- overrun  out  1  one-cycle pulse per dropped sample
- overrun_count  out  8  dropped-sample count, saturates at 255
- frame_count  out  16  frames fully delivered, wraps

## Operation
- Input sync: aud_bclk, aud_adclrck, aud_adcdat each pass a 2-FF synchronizer. BCLK rising edge is detected on the synced signal. LRCK is sampled only at BCLK rising edges.
- I2S deserialize: an LRCK high→low change seen at a BCLK rise arms capture. The next BCLK rise is skipped (I2S one-bit delay). The following SAMPLE_W rises shift in data MSB first. Completion raises an internal sample strobe. Right-channel bits are ignored.
- Bank states per bank: EMPTY, FILLING, FULL, READING.
- Capture side: writes sample strobes into the FILLING bank at wr_idx, then increments wr_idx.
  - At wr_idx = FRAME_LEN-1 write, the bank becomes FULL and wr_idx returns to 0.
  - The other bank becomes FILLING only if it is EMPTY. Otherwise capture enters DROP.
- DROP: each sample strobe pulses overrun and increments overrun_count, saturating at 255.
  - The first strobe after the other bank becomes EMPTY is written at index 0 of that bank. No partial frames.
- Reader FSM states: IDLE, FETCH, STREAM.
  - IDLE → FETCH when any bank is FULL; the older-filled bank goes first, and banks alternate.
  - FETCH: that bank becomes READING and a synchronous read of index 0 is issued.
  - STREAM: holds the registered sample with fft_valid. Advances on fft_valid && fft_ready, with a prefetch register so back-to-back transfers sustain 1 sample/cycle.
  - After the accept of index FRAME_LEN-1: the bank becomes EMPTY and frame_count increments. Next state is FETCH if the other bank is FULL, else IDLE.
- enable low:
  - Discards the in-progress sample and the partial FILLING bank (wr_idx ← 0, bank stays FILLING).
  - DROP exits without counting.
  - The reader finishes its current frame.
  - FULL banks are still delivered.
- Reset values: all outputs 0. Both banks EMPTY, then bank 0 becomes FILLING. wr_idx = 0. Reader in IDLE. Deserializer disarmed.

## Timing
- Sample strobe: 3–4 clk after the synced final BCLK rise. Pin-to-strobe latency is under 4 clk + 2 BCLK periods.
- Frame latency: fft_valid with fft_sop is high 2 clk after the bank's FULL transition (FETCH + read).
- fft_data, fft_sop and fft_eop are stable while fft_valid && !fft_ready. fft_valid never drops mid-frame.
- Simultaneous events:
  - Reader empties bank X in the same cycle capture fills bank Y: capture switches to X without DROP.
  - A sample strobe in the same cycle DROP is released: the sample is written to index 0.
- reset_n assertion mid-frame clears everything immediately. There is no trailing eop.
- overrun is exactly one cycle wide and aligned to the dropped sample strobe.

## Structure
- Shared spectrum_pkg holds: the bank-state enum, the reader-state enum, and the I2S_SKIP_BITS=1 constant.
- Sub-module i2s_rx_sync holds the synchronizers, BCLK edge detect and deserializer. Its outputs are sample_strobe and sample.
- Buffer is 2×FRAME_LEN×SAMPLE_W, inferred as one simple dual-port RAM with synchronous read.

## Test plan
- Reset, then 256 left samples ramp 0x0000..0x00FF with fft_ready=1 → one frame, sop on 0x0000, eop on 0x00FF, frame_count=1, overrun_count=0.
- fft_ready toggling 1-of-3 cycles during frame → identical data order, outputs held while stalled, no drop.
- fft_ready=0 for 3 frames' worth of samples → first two frames buffered. Third frame drops 256 samples, overrun_count=255 (saturated). On release: frames 1 and 2 delivered in order, then capture resumes at index 0.
- enable low after 100 samples, high again → first delivered frame starts with the 1st sample after re-enable.
- reset_n low mid-STREAM at index 50 → fft_valid=0 immediately, counters 0. Next frame after release is complete and sop-aligned.
- Right channel data 0xAAAA, left 0x1234 → only 0x1234 values appear on fft_data.
